data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: round-robin between A and B,
// with an optional bounded lock that gives one port exclusive access for a burst.
module data_mem_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int LOCK_MAX   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic                  a_lock,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic                  b_lock,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr_n,
    output logic                  mem_rd_n,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  lock_timeout,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    state_t           state, state_nxt;
    logic             prio_b, prio_b_nxt;
    logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
    logic             timeout_hit;
    logic             a_rvalid_q, b_rvalid_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            prio_b       <= 1'b0;
            lock_cnt     <= '0;
            lock_timeout <= 1'b0;
            a_rvalid_q   <= 1'b0;
            b_rvalid_q   <= 1'b0;
        end else begin
            state        <= state_nxt;
            prio_b       <= prio_b_nxt;
            lock_cnt     <= lock_cnt_nxt;
            lock_timeout <= timeout_hit;
            a_rvalid_q   <= a_gnt & ~a_we;
            b_rvalid_q   <= b_gnt & ~b_we;
        end
    end

    // Next-state logic; every exit from a lock hands priority to the other port.
    always_comb begin
        state_nxt    = state;
        prio_b_nxt   = prio_b;
        lock_cnt_nxt = lock_cnt;
        timeout_hit  = 1'b0;
        case (state)
            IDLE: begin
                if (a_gnt) begin
                    if (a_lock) begin
                        state_nxt    = LOCK_A;
                        lock_cnt_nxt = '0;
                    end else begin
                        prio_b_nxt = 1'b1;
                    end
                end else if (b_gnt) begin
                    if (b_lock) begin
                        state_nxt    = LOCK_B;
                        lock_cnt_nxt = '0;
                    end else begin
                        prio_b_nxt = 1'b0;
                    end
                end
            end
            LOCK_A: begin
                lock_cnt_nxt = lock_cnt + CNT_W'(1);
                if (!a_lock || lock_cnt == CNT_LAST) begin
                    state_nxt    = IDLE;
                    prio_b_nxt   = 1'b1;
                    lock_cnt_nxt = '0;
                    timeout_hit  = a_lock;
                end
            end
            LOCK_B: begin
                lock_cnt_nxt = lock_cnt + CNT_W'(1);
                if (!b_lock || lock_cnt == CNT_LAST) begin
                    state_nxt    = IDLE;
                    prio_b_nxt   = 1'b0;
                    lock_cnt_nxt = '0;
                    timeout_hit  = b_lock;
                end
            end
            default: begin
                state_nxt    = IDLE;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    // Handshake: a request is held until gnt; gnt is combinational and the access
    // completes at the same rising edge, so a port may drop or change req right after.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    a_gnt = a_req & (~b_req | ~prio_b);
                    b_gnt = b_req & ~a_gnt;
                end
                LOCK_A:  a_gnt = a_req;
                LOCK_B:  b_gnt = b_req;
                default: begin
                    a_gnt = 1'b0;
                    b_gnt = 1'b0;
                end
            endcase
        end
    end

    // Memory-side mux; the bus is driven to all zeros when nobody is granted.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wr_n  = 1'b0;
        mem_rd_n  = 1'b0;
        if (a_gnt) begin
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
            mem_wr_n  = a_we;
            mem_rd_n  = ~a_we;
        end else if (b_gnt) begin
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
            mem_wr_n  = b_we;
            mem_rd_n  = ~b_we;
        end
    end

    // Gating with rst_n kills a read whose return cycle coincides with reset.
    assign a_rvalid  = a_rvalid_q & rst_n;
    assign b_rvalid  = b_rvalid_q & rst_n;
    assign a_rdata   = a_rvalid ? mem_rdata : '0;
    assign b_rdata   = b_rvalid ? mem_rdata : '0;
    assign dbg_state = state;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: contention, forwarding, lock, timeout, reset and idle cases
// against a small synchronous memory model.
module tb_data_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [AW-1:0] a_addr, b_addr, mem_addr;
    logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_wdata, mem_rdata;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic          mem_wr_n, mem_rd_n, lock_timeout;
    logic [1:0]    dbg_state;

    logic [DW-1:0] mem [0:15];
    logic [DW-1:0] exp_q [$];

    int total;
    int bad;

    data_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_wr_n(mem_wr_n), .mem_rd_n(mem_rd_n),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .lock_timeout(lock_timeout), .dbg_state(dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word i starts as 0xA000_0000 + i, read data one cycle after the read edge
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 + i;
            mem_rdata <= '0;
        end else begin
            if (mem_wr_n) mem[mem_addr[3:0]] <= mem_wdata;
            mem_rdata <= mem_rd_n ? mem[mem_addr[3:0]] : '0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic exp_a;
        logic [31:0] exp_d;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_lock = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b1; b_we = 1'b0; b_lock = 1'b0; b_addr = '0; b_wdata = '0;

        // Reset state, with requests present
        repeat (2) @(posedge clk);
        settle();
        check_eq("rst_a_gnt", a_gnt, 0);
        check_eq("rst_b_gnt", b_gnt, 0);
        check_eq("rst_state", dbg_state, 0);
        check_eq("rst_timeout", lock_timeout, 0);
        check_eq("rst_a_rvalid", a_rvalid, 0);
        check_eq("rst_b_rvalid", b_rvalid, 0);
        next_cycle();
        rst_n = 1'b1;
        a_req = 1'b0; b_req = 1'b0;
        next_cycle();

        // Contention: both read for 4 cycles -> A,B,A,B
        a_req = 1'b1; b_req = 1'b1; a_addr = 10'd1; b_addr = 10'd2;
        for (int i = 0; i < 4; i++) begin
            settle();
            exp_a = (i % 2 == 0);
            check_eq($sformatf("cont_a_gnt%0d", i), a_gnt, exp_a);
            check_eq($sformatf("cont_b_gnt%0d", i), b_gnt, !exp_a);
            check_eq($sformatf("cont_addr%0d", i), mem_addr, exp_a ? 1 : 2);
            check_eq($sformatf("cont_rd%0d", i), mem_rd_n, 1);
            if (i > 0) begin
                exp_d = exp_q.pop_front();
                check_eq($sformatf("cont_rvalid%0d", i), exp_a ? b_rvalid : a_rvalid, 1);
                check_eq($sformatf("cont_rdata%0d", i), exp_a ? b_rdata : a_rdata, exp_d);
                check_eq($sformatf("cont_other_rdata%0d", i), exp_a ? a_rdata : b_rdata, 0);
            end
            exp_q.push_back(exp_a ? 32'hA000_0001 : 32'hA000_0002);
            next_cycle();
        end
        a_req = 1'b0; b_req = 1'b0;
        settle();
        exp_d = exp_q.pop_front();
        check_eq("cont_last_rvalid", b_rvalid, 1);
        check_eq("cont_last_rdata", b_rdata, exp_d);
        check_eq("cont_q_empty", exp_q.size(), 0);
        check_eq("cont_no_gnt", a_gnt | b_gnt, 0);
        check_eq("cont_rd_idle", mem_rd_n, 0);
        check_eq("cont_a_rvalid_off", a_rvalid, 0);
        next_cycle();

        // Write then read-back of the same word on consecutive cycles
        a_req = 1'b1; a_we = 1'b1; a_addr = 10'd5; a_wdata = 32'h1234;
        settle();
        check_eq("wr_gnt", a_gnt, 1);
        check_eq("wr_wr_n", mem_wr_n, 1);
        check_eq("wr_rd_n", mem_rd_n, 0);
        check_eq("wr_addr", mem_addr, 5);
        check_eq("wr_wdata", mem_wdata, 32'h1234);
        next_cycle();
        a_we = 1'b0;
        settle();
        check_eq("rd_gnt", a_gnt, 1);
        check_eq("rd_rd_n", mem_rd_n, 1);
        check_eq("wr_no_rvalid", a_rvalid, 0);
        next_cycle();
        a_req = 1'b0;
        settle();
        check_eq("fwd_rvalid", a_rvalid, 1);
        check_eq("fwd_rdata", a_rdata, 32'h1234);
        check_eq("fwd_b_rdata", b_rdata, 0);
        next_cycle();

        // Voluntary lock: B waits while A holds the lock, then wins
        a_req = 1'b1; a_lock = 1'b1; a_addr = 10'd7;
        settle();
        check_eq("lk_a_gnt", a_gnt, 1);
        next_cycle();
        a_req = 1'b0; b_req = 1'b1; b_addr = 10'd3;
        for (int i = 0; i < 3; i++) begin
            settle();
            check_eq($sformatf("lk_b_wait%0d", i), b_gnt, 0);
            check_eq($sformatf("lk_state%0d", i), dbg_state, 1);
            if (i == 0) check_eq("lk_a_rdata", a_rdata, 32'hA000_0007);
            next_cycle();
        end
        a_lock = 1'b0;
        settle();
        check_eq("lk_exit_b_wait", b_gnt, 0);
        check_eq("lk_exit_timeout", lock_timeout, 0);
        next_cycle();
        settle();
        check_eq("lk_after_b_gnt", b_gnt, 1);
        check_eq("lk_after_state", dbg_state, 0);
        next_cycle();
        b_req = 1'b0;
        settle();
        check_eq("lk_b_rdata", b_rdata, 32'hA000_0003);
        check_eq("lk_no_timeout", lock_timeout, 0);
        next_cycle();

        // Forced break after 4 locked cycles
        a_req = 1'b1; a_lock = 1'b1; a_we = 1'b1; a_addr = 10'd9; a_wdata = 32'h55;
        b_req = 1'b1; b_addr = 10'd4;
        settle();
        check_eq("to_a_gnt", a_gnt, 1);
        check_eq("to_b_gnt", b_gnt, 0);
        next_cycle();
        a_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check_eq($sformatf("to_b_wait%0d", i), b_gnt, 0);
            check_eq($sformatf("to_a_hold%0d", i), a_gnt, 1);
            check_eq($sformatf("to_pulse_low%0d", i), lock_timeout, 0);
            check_eq($sformatf("to_state%0d", i), dbg_state, 1);
            if (i == 1) check_eq("to_fwd_rdata", a_rdata, 32'h55);
            next_cycle();
        end
        settle();
        check_eq("to_pulse", lock_timeout, 1);
        check_eq("to_idle", dbg_state, 0);
        check_eq("to_b_gnt_after", b_gnt, 1);
        check_eq("to_a_blocked", a_gnt, 0);
        next_cycle();
        a_req = 1'b0; a_lock = 1'b0; b_req = 1'b0;
        settle();
        check_eq("to_pulse_once", lock_timeout, 0);
        check_eq("to_b_rdata", b_rdata, 32'hA000_0004);
        next_cycle();

        // Reset in the return cycle of a B read
        b_req = 1'b1; b_addr = 10'd6;
        settle();
        check_eq("rr_b_gnt", b_gnt, 1);
        next_cycle();
        rst_n = 1'b0; b_req = 1'b0;
        settle();
        check_eq("rr_b_rvalid", b_rvalid, 0);
        check_eq("rr_b_rdata", b_rdata, 0);
        next_cycle();
        rst_n = 1'b1;
        settle();
        check_eq("rr_state", dbg_state, 0);
        check_eq("rr_b_rvalid_after", b_rvalid, 0);
        next_cycle();

        // Priority returns to A after reset
        a_req = 1'b1; a_addr = 10'd8;
        settle();
        check_eq("rp_a_gnt", a_gnt, 1);
        next_cycle();
        a_req = 1'b0; rst_n = 1'b0;
        settle();
        check_eq("rp_a_rvalid", a_rvalid, 0);
        next_cycle();
        rst_n = 1'b1; a_req = 1'b1; b_req = 1'b1; a_addr = 10'd1; b_addr = 10'd2;
        settle();
        check_eq("rp_prio_a", a_gnt, 1);
        check_eq("rp_prio_b", b_gnt, 0);
        next_cycle();

        // Reset in the middle of a lock
        a_req = 1'b1; a_lock = 1'b1; b_req = 1'b0;
        settle();
        check_eq("rl_a_gnt", a_gnt, 1);
        next_cycle();
        a_req = 1'b0; b_req = 1'b1;
        settle();
        check_eq("rl_b_wait", b_gnt, 0);
        check_eq("rl_state", dbg_state, 1);
        next_cycle();
        rst_n = 1'b0;
        settle();
        check_eq("rl_gnt_in_reset", b_gnt, 0);
        next_cycle();
        rst_n = 1'b1; a_lock = 1'b0;
        settle();
        check_eq("rl_state_idle", dbg_state, 0);
        check_eq("rl_no_timeout", lock_timeout, 0);
        check_eq("rl_b_gnt", b_gnt, 1);
        next_cycle();
        b_req = 1'b0;
        settle();
        check_eq("rl_no_timeout2", lock_timeout, 0);
        next_cycle();

        // Idle bus with non-zero port fields
        a_addr = 10'd9; b_addr = 10'd6; a_wdata = 32'hDEAD; b_wdata = 32'hBEEF;
        a_we = 1'b1; b_we = 1'b1;
        for (int i = 0; i < 10; i++) begin
            settle();
            check_eq($sformatf("idle_wr%0d", i), mem_wr_n, 0);
            check_eq($sformatf("idle_rd%0d", i), mem_rd_n, 0);
            check_eq($sformatf("idle_addr%0d", i), mem_addr, 0);
            check_eq($sformatf("idle_wdata%0d", i), mem_wdata, 0);
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
